output_unit: RTL and testbench
==============================

OUTPUT_UNIT -- requirements
Module: output_unit

Interface
REQ-001 SHALL have parameters: FLIT_W, 64, flit width; NIN, 5, number of input units; DEPTH, 4, downstream buffer depth in flits and burst length.
REQ-002 SHALL have ports: clk  input  1  clock, rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 req  input  NIN  per-input request for this output (input i's out_num equals this port).
REQ-005 flit_in  input  NIN*FLIT_W  flat flit buses; input i occupies [i*FLIT_W +: FLIT_W].
REQ-006 flit_vld  input  NIN  per-input flit valid (input unit push_o).
REQ-007 credit_in  input  1  one-cycle pulse: downstream freed one slot.
REQ-008 vc_grant  output  NIN  one-hot grant pulse to the winning input.
REQ-009 st_ack  output  NIN  one-hot switch-traversal ack pulse to the owner.
REQ-010 out_flit  output  FLIT_W  registered output link data.
REQ-011 out_vld  output  1  registered output link valid.
REQ-012 credits  output  3  current downstream credit count, 0..DEPTH.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 err  output  1  sticky protocol error flag.

Function
REQ-015 SHALL implement states IDLE, GRANT, WAIT_CR, XFER.
REQ-016 IDLE: if req nonzero, pick winner round-robin starting at index (last_winner+1) mod NIN, latch owner, go GRANT; else stay.
REQ-017 GRANT: vc_grant[owner]=1 for exactly this one cycle; next state WAIT_CR.
REQ-018 WAIT_CR: if req[owner]==0, abort to IDLE without updating last_winner; else if credits==DEPTH, st_ack[owner]=1 for this one cycle, clear beat counter, go XFER; else stay.
REQ-019 XFER: each cycle with flit_vld[owner]==1, register flit_in[owner] into out_flit with out_vld=1 next cycle and increment beat counter; flits/valids from non-owners are ignored.
REQ-020 XFER: on the DEPTH-th accepted flit, set last_winner=owner and go IDLE next cycle; new arbitration may start in that IDLE cycle.
REQ-021 out_vld SHALL be 0 in every cycle not following an accepted owner flit; out_flit holds its last value when out_vld=0.
REQ-022 Latency: flit_in to out_flit/out_vld exactly 1 cycle.
REQ-023 credits SHALL decrement by 1 per forwarded flit (out_vld registering) and increment by 1 per credit_in; both in same cycle leaves it unchanged.
REQ-024 credit_in with credits==DEPTH and no simultaneous send SHALL saturate credits at DEPTH and set err.
REQ-025 flit_vld[owner]==1 outside XFER, or a send attempted with credits==0, SHALL set err and the flit SHALL be dropped.
REQ-026 vc_grant and st_ack SHALL never be asserted in the same cycle and SHALL be zero or one-hot.
REQ-027 At most one input owns the port at a time; req changes on non-owners during a transfer SHALL not affect it.

Reset
REQ-028 On reset: state=IDLE, last_winner=NIN-1 (so input 0 wins first), owner=0, beat counter=0, credits=DEPTH, out_flit=0, out_vld=0, vc_grant=0, st_ack=0, busy=0, err=0.
REQ-029 Reset asserted mid-XFER SHALL abandon the burst; no further out_vld until a new grant completes.

Verification
REQ-030 Single burst: reset, req=5'b00100, flit_vld[2] 4 cycles after st_ack[2] -> vc_grant=5'b00100 one cycle, st_ack=5'b00100 one cycle, 4 out_vld beats matching flit_in[2], credits 4->0.
REQ-031 Round-robin: req=5'b10101 held across bursts, credits returned -> owners served in order 0,2,4,0.
REQ-032 Credit stall: credits=0 after burst, req present -> stays WAIT_CR with st_ack=0; four credit_in pulses -> st_ack next cycle after credits reaches 4.
REQ-033 Abort: req[owner] dropped in WAIT_CR -> returns IDLE, no st_ack, last_winner unchanged.
REQ-034 Errors: extra credit_in at credits=4 -> err=1 and credits stays 4; flit_vld from owner in IDLE -> err=1, out_vld stays 0.
REQ-035 Reset mid-XFER after 2 beats -> all outputs at reset values next cycle, credits=4.

Source files
------------

// File: rtl/output_unit_if.sv
// output_unit_if: request, flit and credit signals between the input units,
// one output port and its downstream link.
interface output_unit_if #(
   parameter int FLIT_W = 64,
   parameter int NIN    = 5
);
   logic [NIN-1:0]        req;
   logic [NIN*FLIT_W-1:0] flit_in;
   logic [NIN-1:0]        flit_vld;
   logic                  credit_in;
   logic [NIN-1:0]        vc_grant;
   logic [NIN-1:0]        st_ack;
   logic [FLIT_W-1:0]     out_flit;
   logic                  out_vld;
   logic [2:0]            credits;
   logic                  busy;
   logic                  err;
   modport master (
      output req, flit_in, flit_vld, credit_in,
      input  vc_grant, st_ack, out_flit, out_vld, credits, busy, err
   );
   modport slave (
      input  req, flit_in, flit_vld, credit_in,
      output vc_grant, st_ack, out_flit, out_vld, credits, busy, err
   );
endinterface

// File: rtl/output_unit.sv
// output_unit: round-robin port arbiter with credit-gated, fixed-length burst
// forwarding onto a registered output link.
module output_unit #(
   parameter int FLIT_W = 64,
   parameter int NIN    = 5,
   parameter int DEPTH  = 4
) (
   input logic        clk,
   input logic        reset,
   output_unit_if.slave bus
);
   localparam int OW = (NIN > 1) ? $clog2(NIN) : 1;
   localparam logic [2:0] DEP = 3'(DEPTH);
   typedef enum logic [1:0] {IDLE, GRANT, WAIT_CR, XFER} state_t;
   state_t            r_state, w_next;
   logic [OW-1:0]     r_owner, r_last, w_pick, w_idx;
   logic [2:0]        r_beat, r_cr;
   logic [FLIT_W-1:0] r_flit;
   logic              r_vld, r_err;
   logic [NIN-1:0]    w_oh, w_grant, w_ack;
   logic              w_own_vld, w_accept, w_last_beat, w_err;
   assign w_oh        = NIN'(1) << r_owner;
   assign w_own_vld   = bus.flit_vld[r_owner];
   assign w_accept    = r_state == XFER && w_own_vld && r_cr != 3'd0;
   assign w_last_beat = w_accept && r_beat == DEP - 3'd1;
   // Owner valid outside a burst, sends without credit, and credit overflow.
   assign w_err = (w_own_vld && (r_state != XFER || r_cr == 3'd0)) ||
                  (bus.credit_in && !w_accept && r_cr == DEP);
   // Scan downward so the candidate nearest last_winner+1 is assigned last.
   always_comb begin
      w_pick = '0;
      w_idx  = '0;
      for (int k = NIN; k >= 1; k--) begin
         w_idx = OW'((int'(r_last) + k) % NIN);
         if (bus.req[w_idx]) w_pick = w_idx;
      end
   end
   always_ff @(posedge clk)
      r_state <= reset ? IDLE : w_next;
   always_comb begin
      w_next  = r_state;
      w_grant = '0;
      w_ack   = '0;
      case (r_state)
         IDLE:    w_next = |bus.req ? GRANT : IDLE;
         GRANT: begin
            w_grant = w_oh;
            w_next  = WAIT_CR;
         end
         WAIT_CR: begin
            w_ack  = (bus.req[r_owner] && r_cr == DEP) ? w_oh : '0;
            w_next = !bus.req[r_owner] ? IDLE : (r_cr == DEP) ? XFER : WAIT_CR;
         end
         XFER:    w_next = w_last_beat ? IDLE : XFER;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_owner <= '0;
         r_last  <= OW'(NIN - 1);
         r_beat  <= '0;
         r_cr    <= DEP;
         r_flit  <= '0;
         r_vld   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         if (r_state == IDLE && |bus.req) r_owner <= w_pick;
         r_beat <= |w_ack ? 3'd0 : w_accept ? r_beat + 3'd1 : r_beat;
         if (w_last_beat) r_last <= r_owner;
         if (w_accept) r_flit <= bus.flit_in[r_owner*FLIT_W +: FLIT_W];
         r_vld <= w_accept;
         r_cr  <= (w_accept && !bus.credit_in) ? r_cr - 3'd1 :
                  (bus.credit_in && !w_accept && r_cr != DEP) ? r_cr + 3'd1 : r_cr;
         if (w_err) r_err <= 1'b1;
      end
   end
   assign bus.vc_grant = w_grant;
   assign bus.st_ack   = w_ack;
   assign bus.out_flit = r_flit;
   assign bus.out_vld  = r_vld;
   assign bus.credits  = r_cr;
   assign bus.busy     = r_state != IDLE;
   assign bus.err      = r_err;
endmodule

// File: tb/tb_output_unit.sv
// tb_output_unit: directed single burst, credit stall, reset, error, abort and
// round-robin sequences against hand-computed expectations.
module tb_output_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   output_unit_if #(.FLIT_W(64), .NIN(5)) bus ();
   output_unit #(.FLIT_W(64), .NIN(5), .DEPTH(4)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic rst_chk(input string tag);
      chk({tag, "_vc_grant"}, 64'(bus.vc_grant), 64'd0);
      chk({tag, "_st_ack"},   64'(bus.st_ack),   64'd0);
      chk({tag, "_out_vld"},  64'(bus.out_vld),  64'd0);
      chk({tag, "_out_flit"}, bus.out_flit,      64'd0);
      chk({tag, "_credits"},  64'(bus.credits),  64'd4);
      chk({tag, "_busy"},     64'(bus.busy),     64'd0);
      chk({tag, "_err"},      64'(bus.err),      64'd0);
   endtask
   task automatic burst(input int o, input logic [63:0] base);
      step;
      chk("rr_grant", 64'(bus.vc_grant), 64'(1) << o);
      step;
      chk("rr_ack", 64'(bus.st_ack), 64'(1) << o);
      step;
      for (int b = 0; b < 4; b++) begin
         bus.flit_in = {5{~base}};
         bus.flit_in[o*64 +: 64] = base + 64'(b);
         bus.flit_vld = '0;
         bus.flit_vld[o] = 1'b1;
         bus.credit_in = 1'b1;
         step;
         chk("rr_vld", 64'(bus.out_vld), 64'd1);
         chk("rr_flit", bus.out_flit, base + 64'(b));
         chk("rr_credits", 64'(bus.credits), 64'd4);
      end
      bus.flit_vld = '0;
      bus.credit_in = 1'b0;
   endtask
   initial begin
      bus.req = '0;
      bus.flit_in = '0;
      bus.flit_vld = '0;
      bus.credit_in = 1'b0;
      step;
      step;
      rst_chk("reset");
      reset = 1'b0;
      // single burst from input 2 with a non-owner valid on input 0
      bus.req = 5'b00100;
      step;
      chk("b1_grant", 64'(bus.vc_grant), 64'h04);
      chk("b1_busy", 64'(bus.busy), 64'd1);
      chk("b1_noack", 64'(bus.st_ack), 64'd0);
      step;
      chk("b1_ack", 64'(bus.st_ack), 64'h04);
      chk("b1_grant_off", 64'(bus.vc_grant), 64'd0);
      step;
      chk("b1_ack_off", 64'(bus.st_ack), 64'd0);
      for (int b = 0; b < 4; b++) begin
         bus.flit_in = {5{64'hDEAD_BEEF_DEAD_BEEF}};
         bus.flit_in[2*64 +: 64] = 64'h1111_0000_0000_0000 + 64'(b);
         bus.flit_vld = 5'b00101;
         step;
         chk("b1_vld", 64'(bus.out_vld), 64'd1);
         chk("b1_flit", bus.out_flit, 64'h1111_0000_0000_0000 + 64'(b));
         chk("b1_credits", 64'(bus.credits), 64'(3 - b));
      end
      bus.flit_vld = '0;
      bus.req = '0;
      step;
      chk("b1_vld_off", 64'(bus.out_vld), 64'd0);
      chk("b1_flit_hold", bus.out_flit, 64'h1111_0000_0000_0003);
      chk("b1_idle", 64'(bus.busy), 64'd0);
      chk("b1_err", 64'(bus.err), 64'd0);
      // credit stall: input 2 wins again, waits for four returned credits
      bus.req = 5'b00100;
      step;
      chk("st_grant", 64'(bus.vc_grant), 64'h04);
      step;
      chk("st_noack0", 64'(bus.st_ack), 64'd0);
      chk("st_cr0", 64'(bus.credits), 64'd0);
      step;
      chk("st_noack1", 64'(bus.st_ack), 64'd0);
      chk("st_busy", 64'(bus.busy), 64'd1);
      for (int i = 0; i < 4; i++) begin
         bus.credit_in = 1'b1;
         step;
         chk("st_credits", 64'(bus.credits), 64'(i + 1));
         chk("st_ack", 64'(bus.st_ack), (i == 3) ? 64'h04 : 64'd0);
      end
      bus.credit_in = 1'b0;
      step;
      for (int b = 0; b < 2; b++) begin
         bus.flit_in[2*64 +: 64] = 64'h2222_0000_0000_0000 + 64'(b);
         bus.flit_vld = 5'b00100;
         step;
         chk("st_vld", 64'(bus.out_vld), 64'd1);
         chk("st_credits_dn", 64'(bus.credits), 64'(3 - b));
      end
      // reset in the middle of the burst
      reset = 1'b1;
      bus.flit_vld = '0;
      bus.req = '0;
      step;
      rst_chk("mid_rst");
      reset = 1'b0;
      step;
      chk("mid_rst_novld", 64'(bus.out_vld), 64'd0);
      // credit overflow
      bus.credit_in = 1'b1;
      step;
      bus.credit_in = 1'b0;
      chk("ovf_err", 64'(bus.err), 64'd1);
      chk("ovf_credits", 64'(bus.credits), 64'd4);
      reset = 1'b1;
      step;
      reset = 1'b0;
      chk("err_cleared", 64'(bus.err), 64'd0);
      // owner valid while idle is dropped
      bus.flit_vld = 5'b00001;
      step;
      bus.flit_vld = '0;
      chk("idle_vld_err", 64'(bus.err), 64'd1);
      chk("idle_vld_drop", 64'(bus.out_vld), 64'd0);
      step;
      chk("idle_vld_drop2", 64'(bus.out_vld), 64'd0);
      reset = 1'b1;
      step;
      reset = 1'b0;
      // abort: input 0 drops its request while waiting for the ack
      bus.req = 5'b00011;
      step;
      chk("ab_grant", 64'(bus.vc_grant), 64'h01);
      bus.req = 5'b00010;
      step;
      chk("ab_noack", 64'(bus.st_ack), 64'd0);
      chk("ab_busy", 64'(bus.busy), 64'd1);
      step;
      chk("ab_idle", 64'(bus.busy), 64'd0);
      chk("ab_noack2", 64'(bus.st_ack), 64'd0);
      // round robin: 0 first proves the abort left last_winner alone
      bus.req = 5'b10101;
      burst(0, 64'hA000_0000_0000_0000);
      burst(2, 64'hA200_0000_0000_0000);
      burst(4, 64'hA400_0000_0000_0000);
      burst(0, 64'hB000_0000_0000_0000);
      chk("rr_err", 64'(bus.err), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
